sram_mem_responder: RTL and testbench

//  Memory-side responder for the MEM stage's data requests (MEMread/MEMwrite, byte address, store value).

---
 rtl/sram_mem_responder_pkg.sv | 32 +++
 rtl/sram_phase_counter.sv | 37 +++
 rtl/sram_mem_responder.sv | 149 ++++++++++++++
 tb/tb_sram_mem_responder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/sram_mem_responder_pkg.sv
// Shared types, widths and helpers for the MEM-stage SRAM responder.
package sram_mem_responder_pkg;

   localparam int unsigned BASE_ADDR_DEF = 1024;
   localparam int unsigned DATA_W        = 32;
   localparam int unsigned HALF_W        = 16;
   localparam int unsigned SRAM_AW       = 18;
   localparam int unsigned WORD_IW       = SRAM_AW - 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Transaction captured from the MEM stage when leaving IDLE.
   typedef struct packed {
      logic               wr;
      logic [WORD_IW-1:0] word;
      logic [DATA_W-1:0]  st_val;
   } txn_t;

   // Byte address to SRAM word index; below-base and oversize addresses wrap.
   function automatic logic [WORD_IW-1:0] word_index(input logic [31:0] address,
                                                     input logic [31:0] base);
      logic [31:0] offset;
      offset = address - base;
      return WORD_IW'(offset >> 2);
   endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Down-counter timing one 16-bit SRAM half access.
module sram_phase_counter #(
   parameter int unsigned PHASE_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic last_cycle_c,
   output logic we_window_nxt_c
);

   localparam int unsigned CNT_W = (PHASE_CYCLES > 2) ? $clog2(PHASE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PHASE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;

   // Load at phase entry, count down to zero on the phase's last cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= LOAD_VAL;
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   // Zero count marks the final cycle of the phase.
   assign last_cycle_c = (cnt_q == '0);

   // Whether we_n may be low in the coming cycle (every cycle but the phase's last).
   assign we_window_nxt_c = load ? (LOAD_VAL != '0)
                          : dec  ? (cnt_q > CNT_W'(1))
                          :        (cnt_q != '0);

endmodule

// File: rtl/sram_mem_responder.sv
// MEM-stage responder: splits each 32-bit access into two 16-bit SRAM accesses.
module sram_mem_responder
   import sram_mem_responder_pkg::*;
#(
   parameter int unsigned BASE_ADDR    = BASE_ADDR_DEF,
   parameter int unsigned PHASE_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rd_en,
   input  logic                 wr_en,
   input  logic [DATA_W-1:0]    address,
   input  logic [DATA_W-1:0]    st_val,
   output logic [DATA_W-1:0]    rd_data,
   output logic                 ready,
   output logic [SRAM_AW-1:0]   sram_addr,
   output logic [HALF_W-1:0]    sram_dq_out,
   input  logic [HALF_W-1:0]    sram_dq_in,
   output logic                 sram_dq_oe,
   output logic                 sram_ce_n,
   output logic                 sram_oe_n,
   output logic                 sram_we_n,
   output logic                 sram_ub_n,
   output logic                 sram_lb_n
);

   state_t state_q, state_d;
   txn_t   txn_q, txn_d;
   logic   req;
   logic   load, dec;
   logic   last_cycle_c, we_window_nxt_c;

   logic                phase_d, high_d;
   logic                ce_n_d, oe_n_d, we_n_d, dq_oe_d;
   logic [SRAM_AW-1:0]  addr_d;
   logic [HALF_W-1:0]   dq_out_d;

   assign req = rd_en | wr_en;

   sram_phase_counter #(
      .PHASE_CYCLES (PHASE_CYCLES)
   ) u_phase_counter (
      .clk             (clk),
      .rst             (rst),
      .load            (load),
      .dec             (dec),
      .last_cycle_c    (last_cycle_c),
      .we_window_nxt_c (we_window_nxt_c)
   );

   // Next-state logic; a request is latched only when leaving IDLE.
   always_comb begin
      state_d = state_q;
      txn_d   = txn_q;
      load    = 1'b0;
      dec     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req) begin
               state_d      = ST_LOW;
               load         = 1'b1;
               txn_d.wr     = wr_en;
               txn_d.word   = word_index(address, 32'(BASE_ADDR));
               txn_d.st_val = st_val;
            end
         end
         ST_LOW: begin
            dec = 1'b1;
            if (last_cycle_c) begin
               state_d = ST_HIGH;
               load    = 1'b1;
            end
         end
         ST_HIGH: begin
            dec = 1'b1;
            if (last_cycle_c) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Pin values for the coming cycle, derived from the next state so pins flip with it.
   always_comb begin
      phase_d  = (state_d == ST_LOW) || (state_d == ST_HIGH);
      high_d   = (state_d == ST_HIGH);
      ce_n_d   = ~phase_d;
      oe_n_d   = ~(phase_d & ~txn_d.wr);
      dq_oe_d  = phase_d & txn_d.wr;
      we_n_d   = ~(phase_d & txn_d.wr & we_window_nxt_c);
      addr_d   = sram_addr;
      dq_out_d = sram_dq_out;
      if (phase_d) begin
         addr_d   = {txn_d.word, high_d};
         dq_out_d = high_d ? txn_d.st_val[31:16] : txn_d.st_val[15:0];
      end
   end

   // Pipeline may advance when idle with no request, or in the single DONE cycle.
   assign ready = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);

   // FSM state, latched transaction and read-data assembly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         txn_q   <= '0;
         rd_data <= '0;
      end else begin
         state_q <= state_d;
         txn_q   <= txn_d;
         if ((state_q == ST_LOW) && last_cycle_c && !txn_q.wr) begin
            rd_data[15:0] <= sram_dq_in;
         end
         if ((state_q == ST_HIGH) && last_cycle_c && !txn_q.wr) begin
            rd_data[31:16] <= sram_dq_in;
         end
      end
   end

   // Registered SRAM pin drivers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_ce_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
         sram_we_n   <= 1'b1;
         sram_ub_n   <= 1'b1;
         sram_lb_n   <= 1'b1;
      end else begin
         sram_addr   <= addr_d;
         sram_dq_out <= dq_out_d;
         sram_dq_oe  <= dq_oe_d;
         sram_ce_n   <= ce_n_d;
         sram_oe_n   <= oe_n_d;
         sram_we_n   <= we_n_d;
         sram_ub_n   <= ce_n_d;
         sram_lb_n   <= ce_n_d;
      end
   end

endmodule

// File: tb/tb_sram_mem_responder.sv
// Directed, table-driven bench for sram_mem_responder with a behavioural SRAM.
module tb_sram_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_en, wr_en;
   logic [31:0] address, st_val;
   logic [31:0] rd_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out, sram_dq_in;
   logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

   int errors = 0;
   int checks = 0;

   logic [15:0] mem [0:262143];

   always #5 clk = ~clk;

   sram_mem_responder dut (
      .clk         (clk),
      .rst         (rst),
      .rd_en       (rd_en),
      .wr_en       (wr_en),
      .address     (address),
      .st_val      (st_val),
      .rd_data     (rd_data),
      .ready       (ready),
      .sram_addr   (sram_addr),
      .sram_dq_out (sram_dq_out),
      .sram_dq_in  (sram_dq_in),
      .sram_dq_oe  (sram_dq_oe),
      .sram_ce_n   (sram_ce_n),
      .sram_oe_n   (sram_oe_n),
      .sram_we_n   (sram_we_n),
      .sram_ub_n   (sram_ub_n),
      .sram_lb_n   (sram_lb_n)
   );

   // Behavioural SRAM: writes while ce_n/we_n low with pads driven, reads while oe_n low.
   always @(posedge clk) begin
      if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;
   end
   assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] st;
      logic        drop;
      logic [17:0] lo_addr;
      logic [17:0] hi_addr;
      logic [15:0] lo_data;
      logic [15:0] hi_data;
      logic [31:0] rd_exp;
   } vec_t;

   vec_t vt [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One full transaction: cycle 0 is the first cycle the request is seen.
   task automatic run_txn(input vec_t v, input int idx);
      logic [5:0]  rdy, wel, cel, oel, dqo;
      logic [17:0] a_lo, a_hi;
      logic [15:0] d_lo, d_hi;
      logic [31:0] rdd;
      logic        is_wr;
      is_wr = v.wr;
      rdy = '0; wel = '0; cel = '0; oel = '0; dqo = '0;
      a_lo = '0; a_hi = '0; d_lo = '0; d_hi = '0; rdd = '0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c == 0) begin
            rd_en = v.rd; wr_en = v.wr; address = v.addr; st_val = v.st;
         end
         if (c == 1 && v.drop) begin
            rd_en = 1'b0; wr_en = 1'b0; address = 32'hFFFF_FFF0; st_val = 32'h0;
         end
         #1;
         rdy[c] = ready;
         wel[c] = ~sram_we_n;
         cel[c] = ~sram_ce_n & ~sram_ub_n & ~sram_lb_n;
         oel[c] = ~sram_oe_n;
         dqo[c] = sram_dq_oe;
         if (c == 2) begin a_lo = sram_addr; d_lo = sram_dq_out; end
         if (c == 4) begin a_hi = sram_addr; d_hi = sram_dq_out; end
         if (c == 5) begin
            rdd = rd_data;
            rd_en = 1'b0; wr_en = 1'b0;
         end
      end
      check($sformatf("v%0d ready_pattern", idx), 32'(rdy), 32'(6'b100000));
      check($sformatf("v%0d ce_ub_lb_low", idx), 32'(cel), 32'(6'b011110));
      check($sformatf("v%0d we_low", idx), 32'(wel), is_wr ? 32'(6'b001010) : 32'h0);
      check($sformatf("v%0d oe_low", idx), 32'(oel), is_wr ? 32'h0 : 32'(6'b011110));
      check($sformatf("v%0d dq_oe", idx), 32'(dqo), is_wr ? 32'(6'b011110) : 32'h0);
      check($sformatf("v%0d lo_addr", idx), 32'(a_lo), 32'(v.lo_addr));
      check($sformatf("v%0d hi_addr", idx), 32'(a_hi), 32'(v.hi_addr));
      if (is_wr) begin
         check($sformatf("v%0d lo_data", idx), 32'(d_lo), 32'(v.lo_data));
         check($sformatf("v%0d hi_data", idx), 32'(d_hi), 32'(v.hi_data));
      end
      check($sformatf("v%0d rd_data", idx), rdd, v.rd_exp);
   endtask

   initial begin
      vec_t post;
      //           rd    wr    addr        st             drop  lo_addr   hi_addr   lo_data   hi_data   rd_exp
      vt[0] = '{1'b0, 1'b1, 32'd1024,   32'hDEADBEEF, 1'b0, 18'h00000, 18'h00001, 16'hBEEF, 16'hDEAD, 32'h00000000};
      vt[1] = '{1'b1, 1'b0, 32'd1024,   32'h0,        1'b0, 18'h00000, 18'h00001, 16'h0,    16'h0,    32'hDEADBEEF};
      vt[2] = '{1'b0, 1'b1, 32'd1028,   32'h12345678, 1'b0, 18'h00002, 18'h00003, 16'h5678, 16'h1234, 32'hDEADBEEF};
      vt[3] = '{1'b1, 1'b0, 32'd1028,   32'h0,        1'b0, 18'h00002, 18'h00003, 16'h0,    16'h0,    32'h12345678};
      vt[4] = '{1'b1, 1'b1, 32'd1032,   32'h0000A5A5, 1'b0, 18'h00004, 18'h00005, 16'hA5A5, 16'h0000, 32'h12345678};
      vt[5] = '{1'b0, 1'b1, 32'd1020,   32'hCAFEF00D, 1'b0, 18'h3FFFE, 18'h3FFFF, 16'hF00D, 16'hCAFE, 32'h12345678};
      vt[6] = '{1'b1, 1'b0, 32'd1020,   32'h0,        1'b0, 18'h3FFFE, 18'h3FFFF, 16'h0,    16'h0,    32'hCAFEF00D};
      vt[7] = '{1'b1, 1'b0, 32'd1033,   32'h0,        1'b1, 18'h00004, 18'h00005, 16'h0,    16'h0,    32'h0000A5A5};
      vt[8] = '{1'b0, 1'b1, 32'd525312, 32'h0BADF00D, 1'b0, 18'h00000, 18'h00001, 16'hF00D, 16'h0BAD, 32'h0000A5A5};
      vt[9] = '{1'b1, 1'b0, 32'd1024,   32'h0,        1'b0, 18'h00000, 18'h00001, 16'h0,    16'h0,    32'h0BADF00D};

      for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;

      rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; st_val = '0;
      repeat (3) @(negedge clk);
      #1;
      check("reset ctrl_n", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1F);
      check("reset dq_oe", 32'(sram_dq_oe), 32'h0);
      check("reset rd_data", rd_data, 32'h0);
      check("reset sram_addr", 32'(sram_addr), 32'h0);
      check("reset ready", 32'(ready), 32'h1);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 10; i++) run_txn(vt[i], i);

      @(negedge clk);
      #1;
      check("idle ready", 32'(ready), 32'h1);

      // Reset in the last cycle of the LOW half of a write.
      @(negedge clk);
      wr_en = 1'b1; address = 32'd1040; st_val = 32'h11112222;
      @(negedge clk);
      @(negedge clk);
      #2;
      rst = 1'b0;
      wr_en = 1'b0;
      #1;
      check("abort ctrl_n", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1F);
      check("abort dq_oe", 32'(sram_dq_oe), 32'h0);
      check("abort rd_data", rd_data, 32'h0);
      repeat (3) @(negedge clk);
      #1;
      check("abort ready", 32'(ready), 32'h1);
      rst = 1'b1;

      // Low half survives the abort, high half was never written.
      post = '{1'b1, 1'b0, 32'd1040, 32'h0, 1'b0, 18'h00008, 18'h00009, 16'h0, 16'h0, 32'h00002222};
      run_txn(post, 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
